// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the match judge block: animal index names, the judge
// state encoding and a constant clog2 helper used to size ports and registers.
// No ports (package).
// -----------------------------------------------------------------------------
package game_pkg;

  // Animal indices as decoded from a one-hot choice. Choices beyond CHICKEN
  // exist when NUM_CHOICES > 3 and are simply numbered upward.
  typedef enum int {
    CAT     = 0,
    DOG     = 1,
    CHICKEN = 2
  } animal_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    JUDGE  = 2'd1,
    RESULT = 2'd2,
    OVER   = 2'd3
  } state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/match_judge_if.sv
// -----------------------------------------------------------------------------
// match_judge_if
// Groups the player/controller-facing signals of match_judge.
//   master : the switch/controller side (drives choices and strobes)
//   slave  : the judge itself (drives round result, scores, match status)
// Signals:
//   p1Choice, p2Choice  one-hot player choices
//   roundStart          single-cycle strobe to sample and judge a round
//   resultAck           controller finished drawing the result
//   matchClear          clear scores and start a new match
//   scenario            p1Idx*NUM_CHOICES + p2Idx (sprite select)
//   resultValid         result outputs valid until acked
//   winner1/winner2/tie round outcome, qualified by resultValid
//   invalidChoice       a sampled choice was not one-hot
//   player1/player2     scores (HEX displays)
//   matchOver           a player reached the winning score
//   matchWinner         0 = player 1, 1 = player 2; qualified by matchOver
// -----------------------------------------------------------------------------
interface match_judge_if #(
  parameter int NUM_CHOICES = 3,
  parameter int SCORE_W     = 4
);
  import game_pkg::*;

  localparam int SCEN_W = clog2(NUM_CHOICES * NUM_CHOICES);

  logic [NUM_CHOICES-1:0] p1Choice;
  logic [NUM_CHOICES-1:0] p2Choice;
  logic                   roundStart;
  logic                   resultAck;
  logic                   matchClear;
  logic [SCEN_W-1:0]      scenario;
  logic                   resultValid;
  logic                   winner1;
  logic                   winner2;
  logic                   tie;
  logic                   invalidChoice;
  logic [SCORE_W-1:0]     player1;
  logic [SCORE_W-1:0]     player2;
  logic                   matchOver;
  logic                   matchWinner;

  modport master (
    output p1Choice, p2Choice, roundStart, resultAck, matchClear,
    input  scenario, resultValid, winner1, winner2, tie, invalidChoice,
           player1, player2, matchOver, matchWinner
  );

  modport slave (
    input  p1Choice, p2Choice, roundStart, resultAck, matchClear,
    output scenario, resultValid, winner1, winner2, tie, invalidChoice,
           player1, player2, matchOver, matchWinner
  );

endinterface

// File: rtl/choice_decoder.sv
// -----------------------------------------------------------------------------
// choice_decoder
// Purely combinational one-hot to index decoder for one player's choice.
// Ports:
//   i_onehot  NUM_CHOICES-bit choice pattern
//   o_idx     bit index of the set bit; CAT when the pattern is not one-hot
//   o_valid   1 when exactly one bit of i_onehot is set
// -----------------------------------------------------------------------------
module choice_decoder
  import game_pkg::*;
#(
  parameter int NUM_CHOICES = 3
) (
  input  logic [NUM_CHOICES-1:0]        i_onehot,
  output logic [clog2(NUM_CHOICES)-1:0] o_idx,
  output logic                          o_valid
);

  localparam int IDX_W = clog2(NUM_CHOICES);

  logic [IDX_W-1:0] w_idx;

  // NOTE: every variable written here gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit.
    o_valid = (i_onehot != '0) &&
              ((i_onehot & (i_onehot - NUM_CHOICES'(1))) == '0);
    w_idx   = '0;
    for (int i = 0; i < NUM_CHOICES; i++) begin
      if (i_onehot[i]) w_idx = w_idx | IDX_W'(i);
    end
    o_idx = o_valid ? w_idx : IDX_W'(CAT);
  end

endmodule

// File: rtl/match_judge.sv
// -----------------------------------------------------------------------------
// match_judge
// Latches both players' choices on roundStart, judges the round under the
// generalised rock-paper-scissors rule (d = (p1-p2) mod N: 0 tie, odd p1 wins,
// even p2 wins), keeps per-player scores and runs a first-to-WIN_SCORE match.
// Ports:
//   clk         system clock
//   stateReset  synchronous active-high reset, priority over everything
//   bus         match_judge_if.slave: choices/strobes in, result/scores out
// Latency: roundStart sampled at one edge, results and scores visible after
// the following edge (one JUDGE cycle in between).
// -----------------------------------------------------------------------------
module match_judge
  import game_pkg::*;
#(
  parameter int NUM_CHOICES = 3,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 5
) (
  input  logic          clk,
  input  logic          stateReset,
  match_judge_if.slave  bus
);

  localparam int IDX_W  = clog2(NUM_CHOICES);
  localparam int SCEN_W = clog2(NUM_CHOICES * NUM_CHOICES);
  localparam int DIFF_W = IDX_W + 1;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  state_t                 r_state;
  logic [NUM_CHOICES-1:0] r_p1_choice;
  logic [NUM_CHOICES-1:0] r_p2_choice;
  logic [SCEN_W-1:0]      r_scenario;
  logic                   r_result_valid;
  logic                   r_winner1;
  logic                   r_winner2;
  logic                   r_tie;
  logic                   r_invalid;
  logic [SCORE_W-1:0]     r_player1;
  logic [SCORE_W-1:0]     r_player2;
  logic                   r_match_over;
  logic                   r_match_winner;

  logic [IDX_W-1:0]       w_p1_idx;
  logic [IDX_W-1:0]       w_p2_idx;
  logic                   w_p1_valid;
  logic                   w_p2_valid;
  logic [DIFF_W-1:0]      w_diff_raw;
  logic [DIFF_W-1:0]      w_diff;
  logic                   w_tie;
  logic                   w_p1_wins;
  logic                   w_p2_wins;
  logic [SCEN_W-1:0]      w_scenario;
  logic [SCORE_W-1:0]     w_p1_inc;
  logic [SCORE_W-1:0]     w_p2_inc;

  choice_decoder #(.NUM_CHOICES(NUM_CHOICES)) u_dec_p1 (
    .i_onehot (r_p1_choice),
    .o_idx    (w_p1_idx),
    .o_valid  (w_p1_valid)
  );

  choice_decoder #(.NUM_CHOICES(NUM_CHOICES)) u_dec_p2 (
    .i_onehot (r_p2_choice),
    .o_idx    (w_p2_idx),
    .o_valid  (w_p2_valid)
  );

  // Modular difference without division: the one extra bit acts as a sign,
  // and a negative difference is folded back into 0..N-1 by adding N once.
  assign w_diff_raw = {1'b0, w_p1_idx} - {1'b0, w_p2_idx};
  assign w_diff     = w_diff_raw[DIFF_W-1] ? w_diff_raw + DIFF_W'(NUM_CHOICES)
                                           : w_diff_raw;
  assign w_tie      = (w_diff == '0);
  assign w_p1_wins  = !w_tie && w_diff[0];
  assign w_p2_wins  = !w_tie && !w_diff[0];

  assign w_scenario = SCEN_W'(w_p1_idx) * SCEN_W'(NUM_CHOICES) + SCEN_W'(w_p2_idx);

  // The match ends at WIN_SCORE so these never saturate in normal play.
  assign w_p1_inc = (r_player1 == SCORE_MAX) ? r_player1 : r_player1 + SCORE_W'(1);
  assign w_p2_inc = (r_player2 == SCORE_MAX) ? r_player2 : r_player2 + SCORE_W'(1);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (stateReset) begin
      // NOTE: every register here, including the latched choices, is plain
      // flops with a defined reset value; there is no storage array to clear.
      r_state        <= IDLE;
      r_p1_choice    <= '0;
      r_p2_choice    <= '0;
      r_scenario     <= '0;
      r_result_valid <= 1'b0;
      r_winner1      <= 1'b0;
      r_winner2      <= 1'b0;
      r_tie          <= 1'b0;
      r_invalid      <= 1'b0;
      r_player1      <= '0;
      r_player2      <= '0;
      r_match_over   <= 1'b0;
      r_match_winner <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A clear wins over a simultaneous round start.
          if (bus.matchClear) begin
            r_player1 <= '0;
            r_player2 <= '0;
          end else if (bus.roundStart) begin
            r_p1_choice <= bus.p1Choice;
            r_p2_choice <= bus.p2Choice;
            r_state     <= JUDGE;
          end
        end

        JUDGE: begin
          r_scenario <= w_scenario;
          r_winner1  <= w_p1_wins;
          r_winner2  <= w_p2_wins;
          r_tie      <= w_tie;
          r_invalid  <= !(w_p1_valid && w_p2_valid);
          if (w_p1_wins) begin
            r_player1 <= w_p1_inc;
            if (w_p1_inc == WIN) begin
              r_match_over   <= 1'b1;
              r_match_winner <= 1'b0;
            end
          end
          if (w_p2_wins) begin
            r_player2 <= w_p2_inc;
            if (w_p2_inc == WIN) begin
              r_match_over   <= 1'b1;
              r_match_winner <= 1'b1;
            end
          end
          r_result_valid <= 1'b1;
          r_state        <= RESULT;
        end

        RESULT: begin
          // roundStart is deliberately not looked at here.
          if (bus.resultAck) begin
            r_result_valid <= 1'b0;
            r_state        <= r_match_over ? OVER : IDLE;
          end
        end

        OVER: begin
          if (bus.matchClear) begin
            r_player1      <= '0;
            r_player2      <= '0;
            r_match_over   <= 1'b0;
            r_match_winner <= 1'b0;
            r_state        <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.scenario      = r_scenario;
  assign bus.resultValid   = r_result_valid;
  assign bus.winner1       = r_winner1;
  assign bus.winner2       = r_winner2;
  assign bus.tie           = r_tie;
  assign bus.invalidChoice = r_invalid;
  assign bus.player1       = r_player1;
  assign bus.player2       = r_player2;
  assign bus.matchOver     = r_match_over;
  assign bus.matchWinner   = r_match_winner;

endmodule

// File: tb/tb_match_judge.sv
// -----------------------------------------------------------------------------
// tb_match_judge
// Three judges side by side: default (N=3, WIN=5), a short match (N=3, WIN=2)
// and a five-animal variant (N=5). Inputs are driven #1 after the rising edge
// and outputs are compared at the same point, clear of the active edge.
// -----------------------------------------------------------------------------
module tb_match_judge;
  import game_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v   = '1;
  logic [2:0] start_v = '0;
  logic [2:0] ack_v   = '0;
  logic [2:0] clr_v   = '0;
  logic [4:0] p1_v    = '0;
  logic [4:0] p2_v    = '0;

  int n_checks = 0;
  int n_errors = 0;

  int n_of   [3] = '{3, 3, 5};
  int win_of [3] = '{5, 2, 31};

  // Common observation record for all three instances (zero-extended).
  typedef struct packed {
    logic [7:0] scen;
    logic       rv;
    logic       w1;
    logic       w2;
    logic       tie;
    logic       inv;
    logic [7:0] s1;
    logic [7:0] s2;
    logic       mo;
    logic       mw;
  } obs_t;

  obs_t obs    [3];
  obs_t m_last [3];   // what each instance should be showing right now

  match_judge_if #(.NUM_CHOICES(3), .SCORE_W(4)) bus_a ();
  match_judge_if #(.NUM_CHOICES(3), .SCORE_W(4)) bus_b ();
  match_judge_if #(.NUM_CHOICES(5), .SCORE_W(5)) bus_c ();

  assign bus_a.p1Choice = p1_v[2:0];  assign bus_a.p2Choice = p2_v[2:0];
  assign bus_b.p1Choice = p1_v[2:0];  assign bus_b.p2Choice = p2_v[2:0];
  assign bus_c.p1Choice = p1_v;       assign bus_c.p2Choice = p2_v;
  assign bus_a.roundStart = start_v[0]; assign bus_a.resultAck = ack_v[0]; assign bus_a.matchClear = clr_v[0];
  assign bus_b.roundStart = start_v[1]; assign bus_b.resultAck = ack_v[1]; assign bus_b.matchClear = clr_v[1];
  assign bus_c.roundStart = start_v[2]; assign bus_c.resultAck = ack_v[2]; assign bus_c.matchClear = clr_v[2];

  match_judge #(.NUM_CHOICES(3), .SCORE_W(4), .WIN_SCORE(5)) u_a (
    .clk(clk), .stateReset(rst_v[0]), .bus(bus_a));
  match_judge #(.NUM_CHOICES(3), .SCORE_W(4), .WIN_SCORE(2)) u_b (
    .clk(clk), .stateReset(rst_v[1]), .bus(bus_b));
  match_judge #(.NUM_CHOICES(5), .SCORE_W(5), .WIN_SCORE(31)) u_c (
    .clk(clk), .stateReset(rst_v[2]), .bus(bus_c));

  assign obs[0] = '{8'(bus_a.scenario), bus_a.resultValid, bus_a.winner1, bus_a.winner2,
                    bus_a.tie, bus_a.invalidChoice, 8'(bus_a.player1), 8'(bus_a.player2),
                    bus_a.matchOver, bus_a.matchWinner};
  assign obs[1] = '{8'(bus_b.scenario), bus_b.resultValid, bus_b.winner1, bus_b.winner2,
                    bus_b.tie, bus_b.invalidChoice, 8'(bus_b.player1), 8'(bus_b.player2),
                    bus_b.matchOver, bus_b.matchWinner};
  assign obs[2] = '{8'(bus_c.scenario), bus_c.resultValid, bus_c.winner1, bus_c.winner2,
                    bus_c.tie, bus_c.invalidChoice, 8'(bus_c.player1), 8'(bus_c.player2),
                    bus_c.matchOver, bus_c.matchWinner};

  // Directed vectors for the default instance, applied from reset in order.
  typedef struct {
    logic [4:0] p1;
    logic [4:0] p2;
    int         scen;
    logic       w1;
    logic       w2;
    logic       tie;
    logic       inv;
    int         s1;
    int         s2;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int idx_of(input logic [4:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void ref_judge(input int n, input logic [4:0] a, input logic [4:0] b,
                                    output logic [7:0] scen, output logic w1,
                                    output logic w2, output logic tie, output logic inv);
    int ia, ib, d;
    logic [4:0] mask;
    mask = 5'((1 << n) - 1);
    ia   = idx_of(a & mask);
    ib   = idx_of(b & mask);
    inv  = (ia < 0) || (ib < 0);
    if (ia < 0) ia = CAT;
    if (ib < 0) ib = CAT;
    scen = 8'(ia * n + ib);
    d    = ((ia - ib) % n + n) % n;
    tie  = (d == 0);
    w1   = (d % 2 == 1);
    w2   = !tie && !w1;
  endfunction

  // One full round: strobe, one judge cycle, then the result.
  task automatic play(input int k, input logic [4:0] a, input logic [4:0] b, input string tag);
    logic [7:0] scen;
    logic w1, w2, tie, inv;
    p1_v = a; p2_v = b; start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    check($sformatf("%s judge_cycle", tag), obs[k], m_last[k]);
    ref_judge(n_of[k], a, b, scen, w1, w2, tie, inv);
    m_last[k].scen = scen; m_last[k].w1 = w1; m_last[k].w2 = w2;
    m_last[k].tie  = tie;  m_last[k].inv = inv; m_last[k].rv = 1'b1;
    if (w1) begin
      m_last[k].s1 += 8'd1;
      if (int'(m_last[k].s1) == win_of[k]) begin m_last[k].mo = 1'b1; m_last[k].mw = 1'b0; end
    end
    if (w2) begin
      m_last[k].s2 += 8'd1;
      if (int'(m_last[k].s2) == win_of[k]) begin m_last[k].mo = 1'b1; m_last[k].mw = 1'b1; end
    end
    tick();
    check($sformatf("%s result a=%b b=%b", tag, a, b), obs[k], m_last[k]);
  endtask

  task automatic ack_round(input int k, input string tag);
    tick();
    check($sformatf("%s held", tag), obs[k], m_last[k]);
    ack_v[k] = 1'b1;
    tick();
    ack_v[k] = 1'b0;
    m_last[k].rv = 1'b0;
    check($sformatf("%s acked", tag), obs[k], m_last[k]);
  endtask

  // In OVER: a round start must be ignored, then a clear ends the match.
  task automatic over_seq(input int k, input string tag);
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    tick();
    check($sformatf("%s start_ignored", tag), obs[k], m_last[k]);
    clr_v[k] = 1'b1;
    tick();
    clr_v[k] = 1'b0;
    m_last[k].s1 = '0; m_last[k].s2 = '0; m_last[k].mo = 1'b0; m_last[k].mw = 1'b0;
    check($sformatf("%s cleared", tag), obs[k], m_last[k]);
  endtask

  function automatic logic [4:0] rand_choice(input int n);
    if ($urandom_range(3) == 0) return 5'($urandom_range((1 << n) - 1));
    return 5'(1) << $urandom_range(n - 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5'b00010, 5'b00001, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};  // dog beats cat
    tbl[1] = '{5'b00001, 5'b00001, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0};  // cat ties cat
    tbl[2] = '{5'b00001, 5'b00100, 2, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0};  // cat beats chicken
    tbl[3] = '{5'b00011, 5'b00100, 2, 1'b1, 1'b0, 1'b0, 1'b1, 3, 0};  // invalid p1 -> cat
    tbl[4] = '{5'b00100, 5'b00010, 7, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0};  // chicken beats dog
    tbl[5] = '{5'b00000, 5'b00010, 1, 1'b0, 1'b1, 1'b0, 1'b1, 4, 1};  // empty p1 -> cat, dog wins
    tbl[6] = '{5'b00010, 5'b00100, 5, 1'b0, 1'b1, 1'b0, 1'b0, 4, 2};  // chicken (p2) beats dog
    tbl[7] = '{5'b00110, 5'b00110, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 2};  // both invalid -> tie

    // ---- reset ----
    rst_v = 3'b111;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_state[%0d]", k), obs[k], '0);
      m_last[k] = '0;
    end
    rst_v = 3'b000;

    // ---- directed table on the default instance ----
    for (int i = 0; i < 8; i++) begin
      p1_v = tbl[i].p1; p2_v = tbl[i].p2; start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      check($sformatf("tbl%0d rv_in_judge", i), obs[0].rv, 1'b0);
      tick();
      check($sformatf("tbl%0d rv", i),   obs[0].rv,   1'b1);
      check($sformatf("tbl%0d scen", i), obs[0].scen, tbl[i].scen);
      check($sformatf("tbl%0d w1", i),   obs[0].w1,   tbl[i].w1);
      check($sformatf("tbl%0d w2", i),   obs[0].w2,   tbl[i].w2);
      check($sformatf("tbl%0d tie", i),  obs[0].tie,  tbl[i].tie);
      check($sformatf("tbl%0d inv", i),  obs[0].inv,  tbl[i].inv);
      check($sformatf("tbl%0d p1", i),   obs[0].s1,   tbl[i].s1);
      check($sformatf("tbl%0d p2", i),   obs[0].s2,   tbl[i].s2);
      check($sformatf("tbl%0d mo", i),   obs[0].mo,   1'b0);
      ack_v[0] = 1'b1;
      tick();
      ack_v[0] = 1'b0;
      check($sformatf("tbl%0d rv_after_ack", i), obs[0].rv, 1'b0);
    end
    m_last[0] = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4, 8'd2, 1'b0, 1'b0};

    // ---- roundStart together with resultAck is ignored ----
    play(0, 5'b00001, 5'b00001, "a_tie");
    start_v[0] = 1'b1; ack_v[0] = 1'b1;
    p1_v = 5'b00010; p2_v = 5'b00001;
    tick();
    start_v[0] = 1'b0; ack_v[0] = 1'b0;
    m_last[0].rv = 1'b0;
    check("a_start_with_ack", obs[0], m_last[0]);
    tick();
    tick();
    check("a_no_round_after_ack", obs[0], m_last[0]);

    // ---- clear and start together in IDLE: clear wins ----
    clr_v[0] = 1'b1; start_v[0] = 1'b1;
    tick();
    clr_v[0] = 1'b0; start_v[0] = 1'b0;
    m_last[0].s1 = '0; m_last[0].s2 = '0;
    check("a_clear_beats_start", obs[0], m_last[0]);
    tick();
    tick();
    check("a_no_round_after_clear", obs[0], m_last[0]);

    // ---- randomized rounds against the model ----
    for (int r = 0; r < 60; r++) begin
      play(0, rand_choice(3), rand_choice(3), $sformatf("rnd%0d", r));
      ack_round(0, $sformatf("rnd%0d", r));
      if (m_last[0].mo) over_seq(0, $sformatf("rnd%0d_over", r));
    end

    // ---- short match instance: reset mid-round, then a full match ----
    play(1, 5'b00001, 5'b00010, "b_p2win0");
    ack_round(1, "b_p2win0");
    p1_v = 5'b00010; p2_v = 5'b00001; start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    rst_v[1] = 1'b1;                     // asserted while judging
    tick();
    rst_v[1] = 1'b0;
    check("b_reset_in_judge", obs[1], '0);
    m_last[1] = '0;
    tick();
    check("b_idle_after_reset", obs[1], '0);

    play(1, 5'b00001, 5'b00010, "b_p2win1");
    ack_round(1, "b_p2win1");
    play(1, 5'b00100, 5'b00001, "b_p2win2");
    check("b_match_over",   obs[1].mo, 1'b1);
    check("b_match_winner", obs[1].mw, 1'b1);
    check("b_player2",      obs[1].s2, 8'd2);
    ack_round(1, "b_p2win2");
    over_seq(1, "b_over");
    play(1, 5'b00010, 5'b00001, "b_p1win1");
    ack_round(1, "b_p1win1");
    play(1, 5'b00100, 5'b00010, "b_p1win2");
    check("b_match_winner_p1", obs[1].mw, 1'b0);
    ack_round(1, "b_p1win2");
    over_seq(1, "b_over2");

    // ---- five-animal sweep of all choice pairs ----
    for (int a = 0; a < 5; a++) begin
      for (int b = 0; b < 5; b++) begin
        play(2, 5'(1) << a, 5'(1) << b, $sformatf("c_%0d_%0d", a, b));
        ack_round(2, $sformatf("c_%0d_%0d", a, b));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
